// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: arbitrates freeze, MEM-stage redirect and load-use bubbles.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 32
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             Ext_Stall,
  input  logic             MEM_PCSrc,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rt,
  input  logic             Cnt_Clr,
  output logic             PC_Wr,
  output logic             IFID_Wr,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic [1:0]       Ctrl_State,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt,
  output logic [CNT_W-1:0] Freeze_Cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] bub_q, bub_d;
  logic       lu;
  logic       stall_evt, flush_evt, freeze_evt;

  assign lu = EX_MemRead && (EX_Rt != 5'd0) &&
              ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

  always_comb begin
    state_d    = state_q;
    bub_d      = bub_q;
    stall_evt  = 1'b0;
    flush_evt  = 1'b0;
    freeze_evt = 1'b0;
    if (Ext_Stall) begin
      freeze_evt = 1'b1;
    end else if (MEM_PCSrc) begin
      // Redirect squashes whatever instruction was being held for a load-use bubble
      flush_evt = 1'b1;
      state_d   = ST_RUN;
      bub_d     = 2'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (lu) begin
            stall_evt = 1'b1;
            if (LU_BUBBLES > 1) begin
              state_d = ST_LU_STALL;
              bub_d   = 2'(LU_BUBBLES - 1);
            end
          end
        end
        ST_LU_STALL: begin
          stall_evt = 1'b1;
          bub_d     = bub_q - 2'd1;
          if (bub_q <= 2'd1) begin
            state_d = ST_RUN;
            bub_d   = 2'd0;
          end
        end
        default: begin
          state_d = ST_RUN;
          bub_d   = 2'd0;
        end
      endcase
    end
  end

  // Strobes are forced low while reset is held, independent of the clock
  always_comb begin
    PC_Wr       = 1'b0;
    IFID_Wr     = 1'b0;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    if (Clrn) begin
      PC_Wr       = !(freeze_evt || stall_evt);
      IFID_Wr     = !(freeze_evt || stall_evt);
      IFID_Flush  = flush_evt;
      IDEX_Flush  = flush_evt || stall_evt;
      EXMEM_Flush = flush_evt;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= ST_RUN;
      bub_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  assign Ctrl_State = state_q;

`ifdef HAZ_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_evt  ? sat_inc(stall_cnt_q)  : stall_cnt_q;
    flush_cnt_d  = flush_evt  ? sat_inc(flush_cnt_q)  : flush_cnt_q;
    freeze_cnt_d = freeze_evt ? sat_inc(freeze_cnt_q) : freeze_cnt_q;
    if (Cnt_Clr) begin
      stall_cnt_d  = '0;
      flush_cnt_d  = '0;
      freeze_cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign Stall_Cnt  = stall_cnt_q;
  assign Flush_Cnt  = flush_cnt_q;
  assign Freeze_Cnt = freeze_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = Cnt_Clr;
  assign Stall_Cnt      = '0;
  assign Flush_Cnt      = '0;
  assign Freeze_Cnt     = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances with 1, 2 and 3 load-use bubbles share stimulus.
module tb_pipe_hazard_ctrl;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       Clk, Clrn, Ext_Stall, MEM_PCSrc, ID_UsesRt, EX_MemRead, Cnt_Clr;
  logic [4:0] ID_Rs, ID_Rt, EX_Rt;

  logic        pc1, ifw1, iff1, idf1, exf1;
  logic [1:0]  st1;
  logic [31:0] sc1, fc1, zc1;
  logic        pc2, ifw2, iff2, idf2, exf2;
  logic [1:0]  st2;
  logic [31:0] sc2, fc2, zc2;
  logic        pc3, ifw3, iff3, idf3, exf3;
  logic [1:0]  st3;
  logic [3:0]  sc3, fc3, zc3;

  logic [6:0] v1, v2, v3;
  assign v1 = {pc1, ifw1, iff1, idf1, exf1, st1};
  assign v2 = {pc2, ifw2, iff2, idf2, exf2, st2};
  assign v3 = {pc3, ifw3, iff3, idf3, exf3, st3};

  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(32)) u1 (
    .Clk(Clk), .Clrn(Clrn), .Ext_Stall(Ext_Stall), .MEM_PCSrc(MEM_PCSrc),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .EX_MemRead(EX_MemRead),
    .EX_Rt(EX_Rt), .Cnt_Clr(Cnt_Clr), .PC_Wr(pc1), .IFID_Wr(ifw1), .IFID_Flush(iff1),
    .IDEX_Flush(idf1), .EXMEM_Flush(exf1), .Ctrl_State(st1),
    .Stall_Cnt(sc1), .Flush_Cnt(fc1), .Freeze_Cnt(zc1));

  pipe_hazard_ctrl #(.LU_BUBBLES(2), .CNT_W(32)) u2 (
    .Clk(Clk), .Clrn(Clrn), .Ext_Stall(Ext_Stall), .MEM_PCSrc(MEM_PCSrc),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .EX_MemRead(EX_MemRead),
    .EX_Rt(EX_Rt), .Cnt_Clr(Cnt_Clr), .PC_Wr(pc2), .IFID_Wr(ifw2), .IFID_Flush(iff2),
    .IDEX_Flush(idf2), .EXMEM_Flush(exf2), .Ctrl_State(st2),
    .Stall_Cnt(sc2), .Flush_Cnt(fc2), .Freeze_Cnt(zc2));

  pipe_hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(4)) u3 (
    .Clk(Clk), .Clrn(Clrn), .Ext_Stall(Ext_Stall), .MEM_PCSrc(MEM_PCSrc),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .EX_MemRead(EX_MemRead),
    .EX_Rt(EX_Rt), .Cnt_Clr(Cnt_Clr), .PC_Wr(pc3), .IFID_Wr(ifw3), .IFID_Flush(iff3),
    .IDEX_Flush(idf3), .EXMEM_Flush(exf3), .Ctrl_State(st3),
    .Stall_Cnt(sc3), .Flush_Cnt(fc3), .Freeze_Cnt(zc3));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic set_idle();
    Ext_Stall = 0; MEM_PCSrc = 0; ID_UsesRt = 0; EX_MemRead = 0; Cnt_Clr = 0;
    ID_Rs = 5'd0; ID_Rt = 5'd0; EX_Rt = 5'd0;
  endtask

  task automatic set_lu();
    EX_MemRead = 1; EX_Rt = 5'd8; ID_Rs = 5'd8; ID_Rt = 5'd3; ID_UsesRt = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Clrn = 0;
    set_idle();
    #2;
    checks++;
    if (v1 !== 7'b0000000) begin errors++; $display("FAIL reset_u1: got %b expected %b", v1, 7'b0000000); end
    tick();
    Clrn = 1;
    #2;
    checks++;
    if (v1 !== 7'b1100000) begin errors++; $display("FAIL release_u1: got %b expected %b", v1, 7'b1100000); end
    set_lu();
    tick();
    set_idle();
    #1;
    checks++;
    if (v3 !== 7'b0001001) begin errors++; $display("FAIL pre_reset_stall: got %b expected %b", v3, 7'b0001001); end
    Clrn = 0;
    #1;
    checks++;
    if (v3 !== 7'b0000000) begin errors++; $display("FAIL async_reset_u3: got %b expected %b", v3, 7'b0000000); end
    tick();
    Clrn = 1;
    #2;
    checks++;
    if (v3 !== 7'b1100000) begin errors++; $display("FAIL release_u3: got %b expected %b", v3, 7'b1100000); end
    checks++;
    if (sc1 !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", sc1); end
  endtask

  task automatic test_lu_one_bubble();
    set_lu();
    #2;
    checks++;
    if (v1 !== 7'b0001000) begin errors++; $display("FAIL lu1_stall: got %b expected %b", v1, 7'b0001000); end
    tick();
    set_idle();
    #2;
    checks++;
    if (v1 !== 7'b1100000) begin errors++; $display("FAIL lu1_resume: got %b expected %b", v1, 7'b1100000); end
    repeat (3) tick();
  endtask

  task automatic test_lu_two_bubbles();
    EX_MemRead = 1; EX_Rt = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1;
    #2;
    checks++;
    if (v2 !== 7'b1100000) begin errors++; $display("FAIL lu2_r0: got %b expected %b", v2, 7'b1100000); end
    EX_Rt = 5'd5; ID_Rs = 5'd6; ID_Rt = 5'd5; ID_UsesRt = 0;
    #2;
    checks++;
    if (v2 !== 7'b1100000) begin errors++; $display("FAIL lu2_rt_unused: got %b expected %b", v2, 7'b1100000); end
    ID_UsesRt = 1;
    #2;
    checks++;
    if (v2 !== 7'b0001000) begin errors++; $display("FAIL lu2_c1: got %b expected %b", v2, 7'b0001000); end
    tick();
    set_idle();
    #2;
    checks++;
    if (v2 !== 7'b0001001) begin errors++; $display("FAIL lu2_c2: got %b expected %b", v2, 7'b0001001); end
    tick();
    #1;
    checks++;
    if (v2 !== 7'b1100000) begin errors++; $display("FAIL lu2_done: got %b expected %b", v2, 7'b1100000); end
    repeat (2) tick();
  endtask

  task automatic test_branch_in_stall();
    set_lu();
    tick();
    set_idle();
    MEM_PCSrc = 1;
    #2;
    checks++;
    if (v3 !== 7'b1111101) begin errors++; $display("FAIL t4_flush: got %b expected %b", v3, 7'b1111101); end
    tick();
    MEM_PCSrc = 0;
    #2;
    checks++;
    if (v3 !== 7'b1100000) begin errors++; $display("FAIL t4_run: got %b expected %b", v3, 7'b1100000); end
  endtask

  task automatic test_freeze();
    set_lu();
    tick();
    set_idle();
    Ext_Stall = 1;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (v3 !== 7'b0000001) begin errors++; $display("FAIL freeze_hold_%0d: got %b expected %b", i, v3, 7'b0000001); end
      tick();
    end
    Ext_Stall = 0;
    #2;
    checks++;
    if (v3 !== 7'b0001001) begin errors++; $display("FAIL freeze_resume_b2: got %b expected %b", v3, 7'b0001001); end
    tick();
    #1;
    checks++;
    if (v3 !== 7'b0001001) begin errors++; $display("FAIL freeze_resume_b3: got %b expected %b", v3, 7'b0001001); end
    tick();
    #1;
    checks++;
    if (v3 !== 7'b1100000) begin errors++; $display("FAIL freeze_resume_run: got %b expected %b", v3, 7'b1100000); end
    Cnt_Clr = 1;
    tick();
    Cnt_Clr = 0;
    Ext_Stall = 1; MEM_PCSrc = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++;
      if (v3 !== 7'b0000000) begin errors++; $display("FAIL freeze_branch_%0d: got %b expected %b", i, v3, 7'b0000000); end
      tick();
    end
    Ext_Stall = 0;
    #2;
    checks++;
    if (v3 !== 7'b1111100) begin errors++; $display("FAIL freeze_drop_flush: got %b expected %b", v3, 7'b1111100); end
    tick();
    MEM_PCSrc = 0;
    #2;
    checks++;
    if (v3 !== 7'b1100000) begin errors++; $display("FAIL freeze_after: got %b expected %b", v3, 7'b1100000); end
    checks++;
    if (zc1 !== (PERF ? 32'd4 : 32'd0)) begin errors++; $display("FAIL freeze_cnt: got %0d expected %0d", zc1, PERF ? 4 : 0); end
    checks++;
    if (fc1 !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("FAIL flush_cnt: got %0d expected %0d", fc1, PERF ? 1 : 0); end
    checks++;
    if (sc1 !== 32'd0) begin errors++; $display("FAIL stall_cnt_cleared: got %0d expected 0", sc1); end
  endtask

  task automatic test_saturate();
    Cnt_Clr = 1;
    tick();
    Cnt_Clr = 0;
    set_lu();
    for (int i = 0; i < 20; i++) begin
      #2;
      checks++;
      if (pc3 !== 1'b0) begin errors++; $display("FAIL sat_stall_%0d: got %b expected 0", i, pc3); end
      tick();
    end
    set_idle();
    #1;
    checks++;
    if (sc3 !== (PERF ? 4'd15 : 4'd0)) begin errors++; $display("FAIL stall_cnt_sat: got %0d expected %0d", sc3, PERF ? 15 : 0); end
    checks++;
    if (sc1 !== (PERF ? 32'd20 : 32'd0)) begin errors++; $display("FAIL stall_cnt_20: got %0d expected %0d", sc1, PERF ? 20 : 0); end
    Cnt_Clr = 1;
    #1;
    checks++;
    if (v3 !== 7'b0001001) begin errors++; $display("FAIL sat_tail_stall: got %b expected %b", v3, 7'b0001001); end
    tick();
    Cnt_Clr = 0;
    #1;
    checks++;
    if (sc3 !== 4'd0) begin errors++; $display("FAIL cnt_clr_wins: got %0d expected 0", sc3); end
    tick();
    checks++;
    if (sc3 !== 4'd0) begin errors++; $display("FAIL cnt_after_clr: got %0d expected 0", sc3); end
    checks++;
    if (v3 !== 7'b1100000) begin errors++; $display("FAIL sat_end_run: got %b expected %b", v3, 7'b1100000); end
  endtask

  initial begin
    test_reset();
    test_lu_one_bubble();
    test_lu_two_bubbles();
    test_branch_in_stall();
    test_freeze();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
